// File: rtl/instr_decode_stage.sv
// RV32IM decode stage: combinational decode of the incoming word into a one-hot ALU select,
// register addresses and immediate, buffered in a 2-entry valid/ready FIFO.
module instr_decode_stage #(
  parameter int unsigned INSTR_W = 48,
  parameter int unsigned XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instructions,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  output logic [4:0]         rd_addr,
  output logic [XLEN-1:0]    imm,
  output logic [XLEN-1:0]    pc_out,
  output logic               illegal
);

  typedef struct packed {
    logic [INSTR_W-1:0] ops;
    logic               ill;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
  } entry_t;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  assign imm_sh = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  logic            legal;
  logic [5:0]      op_idx;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    legal   = 1'b1;
    op_idx  = 6'd0;
    dec_imm = '0;
    unique case (opcode)
      7'b0110011: begin
        case (funct7)
          7'h00: begin
            case (funct3)
              3'b000:  op_idx = 6'd0;
              3'b001:  op_idx = 6'd5;
              3'b010:  op_idx = 6'd8;
              3'b011:  op_idx = 6'd9;
              3'b100:  op_idx = 6'd2;
              3'b101:  op_idx = 6'd6;
              3'b110:  op_idx = 6'd3;
              default: op_idx = 6'd4;
            endcase
          end
          7'h20: begin
            if (funct3 == 3'b000)      op_idx = 6'd1;
            else if (funct3 == 3'b101) op_idx = 6'd7;
            else                       legal  = 1'b0;
          end
          // M extension bits follow funct3 order directly
          7'h01:   op_idx = 6'd40 + {3'b000, funct3};
          default: legal  = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec_imm = imm_i;
        case (funct3)
          3'b000: op_idx = 6'd10;
          3'b010: op_idx = 6'd17;
          3'b011: op_idx = 6'd18;
          3'b100: op_idx = 6'd11;
          3'b110: op_idx = 6'd12;
          3'b111: op_idx = 6'd13;
          3'b001: begin
            dec_imm = imm_sh;
            if (funct7 == 7'h00) op_idx = 6'd14;
            else                 legal  = 1'b0;
          end
          default: begin
            dec_imm = imm_sh;
            if (funct7 == 7'h00)      op_idx = 6'd15;
            else if (funct7 == 7'h20) op_idx = 6'd16;
            else                      legal  = 1'b0;
          end
        endcase
      end
      7'b0000011: begin
        dec_imm = imm_i;
        case (funct3)
          3'b000:  op_idx = 6'd19;
          3'b001:  op_idx = 6'd20;
          3'b010:  op_idx = 6'd21;
          3'b100:  op_idx = 6'd22;
          3'b101:  op_idx = 6'd23;
          default: legal  = 1'b0;
        endcase
      end
      7'b0100011: begin
        dec_imm = imm_s;
        case (funct3)
          3'b000:  op_idx = 6'd24;
          3'b001:  op_idx = 6'd25;
          3'b010:  op_idx = 6'd26;
          default: legal  = 1'b0;
        endcase
      end
      7'b1100011: begin
        dec_imm = imm_b;
        case (funct3)
          3'b000:  op_idx = 6'd27;
          3'b001:  op_idx = 6'd28;
          3'b100:  op_idx = 6'd29;
          3'b101:  op_idx = 6'd30;
          3'b110:  op_idx = 6'd31;
          3'b111:  op_idx = 6'd32;
          default: legal  = 1'b0;
        endcase
      end
      7'b1101111: begin
        dec_imm = imm_j;
        op_idx  = 6'd33;
      end
      7'b1100111: begin
        dec_imm = imm_i;
        op_idx  = 6'd34;
        legal   = (funct3 == 3'b000);
      end
      7'b0110111: begin
        dec_imm = imm_u;
        op_idx  = 6'd35;
      end
      7'b0010111: begin
        dec_imm = imm_u;
        op_idx  = 6'd36;
      end
      7'b1110011: begin
        // Only the exact ecall/ebreak encodings; CSR ops are not supported here
        dec_imm = imm_i;
        op_idx  = in_instr[20] ? 6'd38 : 6'd37;
        legal   = (funct3 == 3'b000) && (rs1 == 5'd0) && (rd == 5'd0) &&
                  (in_instr[31:21] == 11'd0);
      end
      7'b0001111: begin
        dec_imm = imm_i;
        op_idx  = 6'd39;
        legal   = (funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
  end

  entry_t dec_entry;

  always_comb begin
    dec_entry     = '0;
    dec_entry.ops = legal ? (INSTR_W'(1) << op_idx) : '0;
    dec_entry.ill = ~legal;
    dec_entry.rs1 = rs1;
    dec_entry.rs2 = rs2;
    dec_entry.rd  = rd;
    dec_entry.imm = (opcode == 7'b0110011) ? '0 : dec_imm;
    dec_entry.pc  = in_pc;
  end

  entry_t     mem_q [2];
  logic       wr_q, rd_q;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready  = ~rst & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_ready & out_valid & ~flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_q <= 1'b0;
        rd_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_q] <= dec_entry;
          wr_q        <= ~wr_q;
        end
        if (pop) rd_q <= ~rd_q;
      end
    end
  end

  entry_t head;

  // Fields read as zero whenever the queue is empty so the ALU select never shows stale ops
  assign head         = out_valid ? mem_q[rd_q] : '0;
  assign instructions = head.ops;
  assign illegal      = head.ill;
  assign rs1_addr     = head.rs1;
  assign rs2_addr     = head.rs2;
  assign rd_addr      = head.rd;
  assign imm          = head.imm;
  assign pc_out       = head.pc;

endmodule
